// File: rtl/irq_pkg.sv
// Interrupt controller shared definitions:
// register map, vector sentinel and priority encoder.
package irq_pkg;

   localparam logic [1:0] IRQ_STATUS = 2'd0;
   localparam logic [1:0] IRQ_ENABLE = 2'd1;
   localparam logic [1:0] IRQ_MODE   = 2'd2;
   localparam logic [1:0] IRQ_VECTOR = 2'd3;

   localparam logic [7:0] VEC_NONE  = 8'h80;
   localparam int         N_SRC_MAX = 8;

   // Lowest set bit wins; VEC_NONE when nothing is set.
   function automatic logic [7:0] prio_vec(input logic [7:0] v);
      logic [7:0] r;
      r = VEC_NONE;
      for (int i = N_SRC_MAX - 1; i >= 0; i--) begin
         if (v[i]) r = 8'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// One interrupt source: 2-flop synchronizer
// plus an edge-detect flop.
module irq_sync
   import irq_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic src,
   output logic level,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= src;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~s3;

endmodule

// File: rtl/irq_controller.sv
// 6502-bus interrupt controller: pending/enable/mode
// registers, priority vector and registered irqb.
module irq_controller
   import irq_pkg::*;
#(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cs,
   input  logic             rwb,
   input  logic [1:0]       addr,
   input  logic [7:0]       data_in,
   output logic [7:0]       data_out,
   input  logic [N_SRC-1:0] src,
   output logic             irqb
);

   logic [N_SRC-1:0] level;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] enable;
   logic [N_SRC-1:0] mode;
   logic [N_SRC-1:0] set_v;
   logic [N_SRC-1:0] clr_v;
   logic [N_SRC-1:0] wdat;
   logic             wr;
   logic             wr_q;
   logic             wr_stb;
   logic [7:0]       vec;

   for (genvar i = 0; i < N_SRC; i++) begin : g_sync
      irq_sync u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .src   (src[i]),
         .level (level[i]),
         .rise  (rise[i])
      );
   end

   // A long CPU write phase commits only on its first cycle.
   assign wr     = cs & ~rwb;
   assign wr_stb = wr & ~wr_q;
   assign wdat   = data_in[N_SRC-1:0];

   assign set_v = (mode & rise) | (~mode & level);
   assign clr_v = (wr_stb && addr == IRQ_STATUS) ? wdat : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q    <= 1'b0;
         pending <= '0;
         enable  <= '0;
         mode    <= '0;
         irqb    <= 1'b1;
      end else begin
         wr_q    <= wr;
         pending <= (pending & ~clr_v) | set_v;
         irqb    <= ~|(pending & enable);
         if (wr_stb && addr == IRQ_ENABLE) enable <= wdat;
         if (wr_stb && addr == IRQ_MODE)   mode   <= wdat;
      end
   end

   assign vec = prio_vec(8'(pending & enable));

   always_comb begin
      data_out = '0;
      unique case (addr)
         IRQ_STATUS: data_out = 8'(pending);
         IRQ_ENABLE: data_out = 8'(enable);
         IRQ_MODE:   data_out = 8'(mode);
         IRQ_VECTOR: data_out = vec;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller against
// a cycle-level reference model of the register rules.
module tb_irq_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs = 1'b0;
   logic       rwb = 1'b1;
   logic [1:0] addr = 2'd0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic [7:0] src = 8'h00;
   logic       irqb;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [7:0] m_pend, m_en, m_mode;
   logic [7:0] d1, d2, d3;
   logic       m_irqb, m_wrp;

   irq_controller #(.N_SRC(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cs       (cs),
      .rwb      (rwb),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .src      (src),
      .irqb     (irqb)
   );

   always #10 clk = ~clk;

   // d1/d2/d3: raw src seen 1/2/3 edges ago
   task automatic model_edge();
      logic [7:0] set, clr;
      logic       stb;
      if (!rst_n) begin
         m_pend = 0; m_en = 0; m_mode = 0;
         m_irqb = 1; m_wrp = 0;
         d1 = 0; d2 = 0; d3 = 0;
      end else begin
         m_irqb = ((m_pend & m_en) == 8'h00);
         set = (m_mode & d2 & ~d3) | (~m_mode & d2);
         stb = cs && !rwb && !m_wrp;
         clr = (stb && addr == 2'd0) ? data_in : 8'h00;
         m_pend = (m_pend & ~clr) | set;
         if (stb && addr == 2'd1) m_en = data_in;
         if (stb && addr == 2'd2) m_mode = data_in;
         m_wrp = cs && !rwb;
         d3 = d2; d2 = d1; d1 = src;
      end
   endtask

   function automatic logic [7:0] mrd(input logic [1:0] a);
      logic [7:0] act;
      int k;
      case (a)
         2'd0: return m_pend;
         2'd1: return m_en;
         2'd2: return m_mode;
         default: begin
            act = m_pend & m_en;
            if (act == 0) return 8'h80;
            k = 0;
            while (!act[k]) k++;
            return 8'(k);
         end
      endcase
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      logic [1:0] old;
      old = addr;
      addr = a;
      #1;
      d = data_out;
      addr = old;
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      addr = a; data_in = d; cs = 1; rwb = 0;
      cycle();
      cs = 0; rwb = 1;
      cycle();
   endtask

   task automatic test_reset();
      logic [7:0] d;
      logic [7:0] exp [4];
      exp = '{8'h00, 8'h00, 8'h00, 8'h80};
      rst_n = 0;
      cycles(2);
      rst_n = 1;
      checks++;
      if (irqb !== 1'b1) begin
         errors++;
         $display("FAIL reset_irqb got %b exp 1", irqb);
      end
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         checks++;
         if (d !== exp[a]) begin
            errors++;
            $display("FAIL reset_reg%0d got %h exp %h", a, d, exp[a]);
         end
      end
   endtask

   task automatic test_edge();
      logic [7:0] d;
      wr(2'd1, 8'h03);
      wr(2'd2, 8'h01);
      src[0] = 1;
      cycle();
      src[0] = 0;
      cycles(2);
      rd(2'd0, d);
      checks++;
      if (d !== 8'h01 || irqb !== 1'b1) begin
         errors++;
         $display("FAIL edge_k2 got st=%h irqb=%b exp 01/1", d, irqb);
      end
      cycle();
      rd(2'd3, d);
      checks++;
      if (d !== 8'h00 || irqb !== 1'b0) begin
         errors++;
         $display("FAIL edge_k3 got vec=%h irqb=%b exp 00/0", d, irqb);
      end
      wr(2'd0, 8'h01);
      checks++;
      if (irqb !== 1'b1 || irqb !== m_irqb) begin
         errors++;
         $display("FAIL edge_clr got irqb=%b exp 1", irqb);
      end
   endtask

   task automatic test_level();
      logic [7:0] d;
      wr(2'd2, 8'h00);
      wr(2'd1, 8'h02);
      src[1] = 1;
      cycles(4);
      wr(2'd0, 8'h02);
      rd(2'd0, d);
      checks++;
      if (d !== 8'h02 || irqb !== 1'b0) begin
         errors++;
         $display("FAIL level_hold got st=%h irqb=%b exp 02/0", d, irqb);
      end
      src[1] = 0;
      cycles(3);
      wr(2'd0, 8'h02);
      rd(2'd0, d);
      checks++;
      if (d !== 8'h00 || irqb !== 1'b1) begin
         errors++;
         $display("FAIL level_drop got st=%h irqb=%b exp 00/1", d, irqb);
      end
   endtask

   task automatic test_priority();
      logic [7:0] d, s;
      logic [7:0] ens [3];
      logic [7:0] vecs [3];
      ens  = '{8'hFF, 8'h20, 8'h00};
      vecs = '{8'h02, 8'h05, 8'h80};
      wr(2'd1, 8'h00);
      src = 8'h24;
      cycle();
      src = 8'h00;
      cycles(3);
      for (int i = 0; i < 3; i++) begin
         wr(2'd1, ens[i]);
         rd(2'd3, d);
         rd(2'd0, s);
         checks++;
         if (d !== vecs[i] || s !== 8'h24 ||
             irqb !== (ens[i] & 8'h24) == 0) begin
            errors++;
            $display("FAIL prio_%0d got vec=%h st=%h irqb=%b exp %h/24",
                     i, d, s, irqb, vecs[i]);
         end
      end
      wr(2'd0, 8'h24);
   endtask

   task automatic test_held_write();
      logic [7:0] d;
      wr(2'd2, 8'h01);
      wr(2'd1, 8'h01);
      src[0] = 1;
      cycle();
      src[0] = 0;
      cycles(3);
      addr = 2'd0; data_in = 8'h01; cs = 1; rwb = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) src[0] = 1;
         cycle();
         if (i == 0) begin
            rd(2'd0, d);
            checks++;
            if (d !== 8'h00) begin
               errors++;
               $display("FAIL held_first got %h exp 00", d);
            end
         end
      end
      cs = 0; rwb = 1;
      cycle();
      rd(2'd0, d);
      checks++;
      if (d !== 8'h01 || d !== m_pend) begin
         errors++;
         $display("FAIL held_after got %h exp 01", d);
      end
      src[0] = 0;
      cycles(3);
      wr(2'd0, 8'h01);
   endtask

   task automatic test_collision();
      logic [7:0] d;
      src[0] = 1;
      cycles(2);
      addr = 2'd0; data_in = 8'h01; cs = 1; rwb = 0;
      cycle();
      cs = 0; rwb = 1;
      rd(2'd0, d);
      checks++;
      if (d !== 8'h01) begin
         errors++;
         $display("FAIL collide got %h exp 01", d);
      end
      cycles(2);
      checks++;
      if (irqb !== 1'b0) begin
         errors++;
         $display("FAIL collide_irqb got %b exp 0", irqb);
      end
      rst_n = 0;
      cycle();
      rst_n = 1;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         checks++;
         if (d !== (a == 3 ? 8'h80 : 8'h00) || irqb !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid reg%0d got %h irqb=%b", a, d, irqb);
         end
      end
      src[0] = 0;
      cycles(3);
   endtask

   task automatic test_random();
      logic [7:0] d;
      for (int n = 0; n < 400; n++) begin
         src = 8'($urandom) & 8'($urandom);
         rst_n = ($urandom_range(0, 149) != 0);
         if (cs) begin
            if ($urandom_range(0, 2) == 0) begin
               cs = 0; rwb = 1;
            end
         end else if ($urandom_range(0, 5) == 0) begin
            addr = 2'($urandom);
            data_in = 8'($urandom);
            cs = 1; rwb = 0;
         end
         cycle();
         checks++;
         if (irqb !== m_irqb) begin
            errors++;
            $display("FAIL rand_irqb n=%0d got %b exp %b", n, irqb, m_irqb);
         end
         for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== mrd(2'(a))) begin
               errors++;
               $display("FAIL rand_reg%0d n=%0d got %h exp %h",
                        a, n, d, mrd(2'(a)));
            end
         end
      end
      cs = 0; rwb = 1; rst_n = 1; src = 0;
      cycles(4);
   endtask

   initial begin
      #1;
      test_reset();
      test_edge();
      test_level();
      test_priority();
      test_held_write();
      test_collision();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
